// File: rtl/wb_arbiter.sv
// ---------------------------------------------------------------------------
// wb_arbiter
//   Writeback-stage arbiter that merges the scalar pipeline and the
//   fixed-latency vector pipeline onto the single scalar-RF write port and
//   the single vector-RF write port.
//
//   The vector pipe never stalls and always wins its port.  A scalar-pipe
//   write that cannot go out this cycle is queued in a per-port FIFO.  Once
//   either FIFO is full, the scalar pipe is stalled.  Scalar writes always
//   retire in issue order: while a FIFO holds entries, new scalar writes for
//   that port are queued behind them instead of being sent direct.
//
//   Optional build macro: WB_PERF_CNT_EN adds conflict_cnt / stall_cnt.
//
// Ports
//   clk, rst_n                  clock, asynchronous active-low reset
//   s_reg_*  / s_pc_sel, s_pc   scalar pipe -> scalar-RF request (link = PC)
//   v_reg_*                     vector pipe -> scalar-RF request
//   s_vec_*                     scalar pipe -> vector-RF request
//   v_vec_*                     vector pipe -> vector-RF request
//   reg_we/wbr/data             scalar-RF write port (registered)
//   vec_we/wbr/data/mask        vector-RF write port (registered)
//   reg_pending, vec_pending    one bit per register with a queued write
//   stall                       a FIFO is full; scalar pipe must hold
//   err                         sticky: scalar write presented while stalled
//   conflict_cnt, stall_cnt     perf counters (WB_PERF_CNT_EN only)
// ---------------------------------------------------------------------------
module wb_arbiter #(
    parameter int BUF_DEPTH = 4,
    parameter int SDATA_W   = 36,
    parameter int VLANE_W   = 32,
    parameter int VLANES    = 4,
    parameter int RADDR_W   = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        s_reg_we,
    input  logic [RADDR_W-1:0]          s_reg_wbr,
    input  logic [SDATA_W-1:0]          s_reg_data,
    input  logic                        s_pc_sel,
    input  logic [SDATA_W-1:0]          s_pc,
    input  logic                        v_reg_we,
    input  logic [RADDR_W-1:0]          v_reg_wbr,
    input  logic [SDATA_W-1:0]          v_reg_data,
    input  logic                        s_vec_we,
    input  logic [RADDR_W-1:0]          s_vec_wbr,
    input  logic [VLANES*VLANE_W-1:0]   s_vec_data,
    input  logic [VLANES-1:0]           s_vec_mask,
    input  logic                        v_vec_we,
    input  logic [RADDR_W-1:0]          v_vec_wbr,
    input  logic [VLANES*VLANE_W-1:0]   v_vec_data,
    input  logic [VLANES-1:0]           v_vec_mask,
    output logic                        reg_we,
    output logic [RADDR_W-1:0]          reg_wbr,
    output logic [SDATA_W-1:0]          reg_data,
    output logic                        vec_we,
    output logic [RADDR_W-1:0]          vec_wbr,
    output logic [VLANES*VLANE_W-1:0]   vec_data,
    output logic [VLANES-1:0]           vec_mask,
    output logic [2**RADDR_W-1:0]       reg_pending,
    output logic [2**RADDR_W-1:0]       vec_pending,
    output logic                        stall,
`ifdef WB_PERF_CNT_EN
    output logic [31:0]                 conflict_cnt,
    output logic [31:0]                 stall_cnt,
`endif
    output logic                        err
);

    localparam int PTR_W   = $clog2(BUF_DEPTH);
    localparam int CNT_W   = PTR_W + 1;
    localparam int VDATA_W = VLANES * VLANE_W;

    // FIFO storage is never reset; validity comes from pointers and count.
    logic [RADDR_W-1:0] rq_wbr  [BUF_DEPTH];
    logic [SDATA_W-1:0] rq_data [BUF_DEPTH];
    logic [PTR_W-1:0]   rq_rd, rq_wr;
    logic [CNT_W-1:0]   rq_cnt;

    logic [RADDR_W-1:0] vq_wbr  [BUF_DEPTH];
    logic [VDATA_W-1:0] vq_data [BUF_DEPTH];
    logic [VLANES-1:0]  vq_mask [BUF_DEPTH];
    logic [PTR_W-1:0]   vq_rd, vq_wr;
    logic [CNT_W-1:0]   vq_cnt;

    logic [SDATA_W-1:0] s_data;
    logic               rq_empty, vq_empty;
    logic               s_reg_ok, s_vec_ok;
    logic               rq_push, rq_pop, rq_direct;
    logic               vq_push, vq_pop, vq_direct;

    // Link writes carry the return PC; the choice is made before queueing.
    assign s_data = s_pc_sel ? s_pc : s_reg_data;

    // stall depends only on the registered counts.
    assign stall    = (rq_cnt == CNT_W'(BUF_DEPTH)) | (vq_cnt == CNT_W'(BUF_DEPTH));
    assign rq_empty = (rq_cnt == '0);
    assign vq_empty = (vq_cnt == '0);

    // Requests seen while stalled are dropped outright.
    assign s_reg_ok = s_reg_we & ~stall;
    assign s_vec_ok = s_vec_we & ~stall;

    // A scalar write goes direct only when nothing is ahead of it; otherwise
    // it is queued to preserve issue order.
    assign rq_pop    = ~v_reg_we & ~rq_empty;
    assign rq_push   = s_reg_ok & (v_reg_we | ~rq_empty);
    assign rq_direct = s_reg_ok & ~v_reg_we & rq_empty;

    assign vq_pop    = ~v_vec_we & ~vq_empty;
    assign vq_push   = s_vec_ok & (v_vec_we | ~vq_empty);
    assign vq_direct = s_vec_ok & ~v_vec_we & vq_empty;

    always_ff @(posedge clk) begin
        if (rq_push) begin
            rq_wbr[rq_wr]  <= s_reg_wbr;
            rq_data[rq_wr] <= s_data;
        end
        if (vq_push) begin
            vq_wbr[vq_wr]  <= s_vec_wbr;
            vq_data[vq_wr] <= s_vec_data;
            vq_mask[vq_wr] <= s_vec_mask;
        end
    end

    // FIFO control and registered write ports.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rq_rd    <= '0;
            rq_wr    <= '0;
            rq_cnt   <= '0;
            vq_rd    <= '0;
            vq_wr    <= '0;
            vq_cnt   <= '0;
            reg_we   <= 1'b0;
            reg_wbr  <= '0;
            reg_data <= '0;
            vec_we   <= 1'b0;
            vec_wbr  <= '0;
            vec_data <= '0;
            vec_mask <= '0;
            err      <= 1'b0;
        end else begin
            if (rq_push) rq_wr <= rq_wr + PTR_W'(1);
            if (rq_pop)  rq_rd <= rq_rd + PTR_W'(1);
            case ({rq_push, rq_pop})
                2'b10:   rq_cnt <= rq_cnt + CNT_W'(1);
                2'b01:   rq_cnt <= rq_cnt - CNT_W'(1);
                default: rq_cnt <= rq_cnt;
            endcase

            if (vq_push) vq_wr <= vq_wr + PTR_W'(1);
            if (vq_pop)  vq_rd <= vq_rd + PTR_W'(1);
            case ({vq_push, vq_pop})
                2'b10:   vq_cnt <= vq_cnt + CNT_W'(1);
                2'b01:   vq_cnt <= vq_cnt - CNT_W'(1);
                default: vq_cnt <= vq_cnt;
            endcase

            // Scalar-RF port: vector pipe, then FIFO head, then direct.
            if (v_reg_we) begin
                reg_we   <= 1'b1;
                reg_wbr  <= v_reg_wbr;
                reg_data <= v_reg_data;
            end else if (rq_pop) begin
                reg_we   <= 1'b1;
                reg_wbr  <= rq_wbr[rq_rd];
                reg_data <= rq_data[rq_rd];
            end else if (rq_direct) begin
                reg_we   <= 1'b1;
                reg_wbr  <= s_reg_wbr;
                reg_data <= s_data;
            end else begin
                reg_we   <= 1'b0;
            end

            // Vector-RF port: same priority; a zero mask still writes.
            if (v_vec_we) begin
                vec_we   <= 1'b1;
                vec_wbr  <= v_vec_wbr;
                vec_data <= v_vec_data;
                vec_mask <= v_vec_mask;
            end else if (vq_pop) begin
                vec_we   <= 1'b1;
                vec_wbr  <= vq_wbr[vq_rd];
                vec_data <= vq_data[vq_rd];
                vec_mask <= vq_mask[vq_rd];
            end else if (vq_direct) begin
                vec_we   <= 1'b1;
                vec_wbr  <= s_vec_wbr;
                vec_data <= s_vec_data;
                vec_mask <= s_vec_mask;
            end else begin
                vec_we   <= 1'b0;
            end

            if ((s_reg_we | s_vec_we) & stall) err <= 1'b1;
        end
    end

    // An entry is live when its distance from the read pointer is below count.
    always_comb begin
        logic [PTR_W-1:0] rq_off;
        logic [PTR_W-1:0] vq_off;
        reg_pending = '0;
        vec_pending = '0;
        rq_off      = '0;
        vq_off      = '0;
        for (int i = 0; i < BUF_DEPTH; i++) begin
            rq_off = PTR_W'(i) - rq_rd;
            vq_off = PTR_W'(i) - vq_rd;
            if (CNT_W'(rq_off) < rq_cnt) reg_pending[rq_wbr[i]] = 1'b1;
            if (CNT_W'(vq_off) < vq_cnt) vec_pending[vq_wbr[i]] = 1'b1;
        end
    end

`ifdef WB_PERF_CNT_EN
    // A conflict cycle is one where a scalar write had to be queued.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt <= '0;
            stall_cnt    <= '0;
        end else begin
            if ((rq_push | vq_push) && conflict_cnt != 32'hFFFF_FFFF)
                conflict_cnt <= conflict_cnt + 32'd1;
            if (stall && stall_cnt != 32'hFFFF_FFFF)
                stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
module tb_wb_arbiter;

    localparam int DEPTH = 4;
    localparam int SW    = 36;
    localparam int VW    = 128;
    localparam int AW    = 5;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          s_reg_we = 0, s_pc_sel = 0, v_reg_we = 0, s_vec_we = 0, v_vec_we = 0;
    logic [AW-1:0] s_reg_wbr = 0, v_reg_wbr = 0, s_vec_wbr = 0, v_vec_wbr = 0;
    logic [SW-1:0] s_reg_data = 0, s_pc = 0, v_reg_data = 0;
    logic [VW-1:0] s_vec_data = 0, v_vec_data = 0;
    logic [3:0]    s_vec_mask = 0, v_vec_mask = 0;

    logic          reg_we, vec_we, stall, err;
    logic [AW-1:0] reg_wbr, vec_wbr;
    logic [SW-1:0] reg_data;
    logic [VW-1:0] vec_data;
    logic [3:0]    vec_mask;
    logic [31:0]   reg_pending, vec_pending;
`ifdef WB_PERF_CNT_EN
    logic [31:0]   conflict_cnt, stall_cnt;
`endif

    wb_arbiter #(.BUF_DEPTH(DEPTH), .SDATA_W(SW), .VLANE_W(32), .VLANES(4), .RADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_reg_we(s_reg_we), .s_reg_wbr(s_reg_wbr), .s_reg_data(s_reg_data),
        .s_pc_sel(s_pc_sel), .s_pc(s_pc),
        .v_reg_we(v_reg_we), .v_reg_wbr(v_reg_wbr), .v_reg_data(v_reg_data),
        .s_vec_we(s_vec_we), .s_vec_wbr(s_vec_wbr), .s_vec_data(s_vec_data), .s_vec_mask(s_vec_mask),
        .v_vec_we(v_vec_we), .v_vec_wbr(v_vec_wbr), .v_vec_data(v_vec_data), .v_vec_mask(v_vec_mask),
        .reg_we(reg_we), .reg_wbr(reg_wbr), .reg_data(reg_data),
        .vec_we(vec_we), .vec_wbr(vec_wbr), .vec_data(vec_data), .vec_mask(vec_mask),
        .reg_pending(reg_pending), .vec_pending(vec_pending), .stall(stall),
`ifdef WB_PERF_CNT_EN
        .conflict_cnt(conflict_cnt), .stall_cnt(stall_cnt),
`endif
        .err(err)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [AW-1:0] wbr; logic [SW-1:0] data; } rw_t;
    typedef struct packed { logic [AW-1:0] wbr; logic [VW-1:0] data; logic [3:0] mask; } vw_t;

    // Reference model: the writes still waiting in each FIFO, and the
    // scoreboard of writes expected to appear on each RF port.
    rw_t mreg[$];
    vw_t mvec[$];
    rw_t exp_reg[$];
    vw_t exp_vec[$];
    rw_t last_reg;
    vw_t last_vec;
    bit  merr;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string nm, input logic [255:0] act, input logic [255:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s: actual=%0h required=%0h", nm, act, req);
    endtask

    function automatic logic [31:0] reg_pend_model();
        logic [31:0] p = '0;
        foreach (mreg[i]) p[mreg[i].wbr] = 1'b1;
        return p;
    endfunction

    function automatic logic [31:0] vec_pend_model();
        logic [31:0] p = '0;
        foreach (mvec[i]) p[mvec[i].wbr] = 1'b1;
        return p;
    endfunction

    function automatic bit model_stall();
        return (mreg.size() == DEPTH) || (mvec.size() == DEPTH);
    endfunction

    // Monitor: pops the scoreboard whenever a port writes; otherwise the
    // port must hold its last address/data.
    initial begin
        rw_t er;
        vw_t ev;
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (reg_we) begin
                    if (exp_reg.size() == 0) check("reg_unexpected_write", 1, 0);
                    else begin
                        er = exp_reg.pop_front();
                        check("reg_write", {reg_wbr, reg_data}, er);
                        last_reg = er;
                    end
                end else begin
                    check("reg_hold", {reg_wbr, reg_data}, last_reg);
                end
                if (vec_we) begin
                    if (exp_vec.size() == 0) check("vec_unexpected_write", 1, 0);
                    else begin
                        ev = exp_vec.pop_front();
                        check("vec_write", {vec_wbr, vec_data, vec_mask}, ev);
                        last_vec = ev;
                    end
                end else begin
                    check("vec_hold", {vec_wbr, vec_data, vec_mask}, last_vec);
                end
            end
        end
    end

    // One cycle: check state outputs against the model, advance the model
    // with the inputs being presented, drive them, and move to the next
    // sampling point (just after the following falling edge).
    task automatic step();
        bit st;
        check("stall", stall, model_stall());
        check("reg_pending", reg_pending, reg_pend_model());
        check("vec_pending", vec_pending, vec_pend_model());
        check("err", err, merr);

        st = model_stall();
        if ((s_reg_we || s_vec_we) && st) merr = 1'b1;
        // Scalar writes join the back of their in-order stream; each port
        // retires the oldest one unless the vector pipe claims the port.
        if (s_reg_we && !st) mreg.push_back('{s_reg_wbr, s_pc_sel ? s_pc : s_reg_data});
        if (v_reg_we) exp_reg.push_back('{v_reg_wbr, v_reg_data});
        else if (mreg.size() > 0) exp_reg.push_back(mreg.pop_front());
        if (s_vec_we && !st) mvec.push_back('{s_vec_wbr, s_vec_data, s_vec_mask});
        if (v_vec_we) exp_vec.push_back('{v_vec_wbr, v_vec_data, v_vec_mask});
        else if (mvec.size() > 0) exp_vec.push_back(mvec.pop_front());

        @(negedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        s_reg_we = 0; s_pc_sel = 0; v_reg_we = 0; s_vec_we = 0; v_vec_we = 0;
    endtask

    function automatic logic [VW-1:0] rand_vec();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        idle_inputs();
        mreg.delete(); mvec.delete(); exp_reg.delete(); exp_vec.delete();
        last_reg = '0; last_vec = '0; merr = 0;
        @(negedge clk); #1;
        @(negedge clk); #1;
        check("rst_reg_we", reg_we, 0);
        check("rst_vec_we", vec_we, 0);
        check("rst_reg_port", {reg_wbr, reg_data}, 0);
        check("rst_vec_port", {vec_wbr, vec_data, vec_mask}, 0);
        check("rst_pending", {reg_pending, vec_pending}, 0);
        check("rst_stall_err", {stall, err}, 0);
        rst_n = 1'b1;
    endtask

    // Fill the vector FIFO behind a busy vector pipe until the model says full.
    task automatic fill_vec(input int vcycles);
        int pushes = 0;
        for (int c = 0; c < vcycles; c++) begin
            v_vec_we = 1; v_vec_wbr = AW'(c); v_vec_data = rand_vec(); v_vec_mask = 4'($urandom);
            s_vec_we = (mvec.size() < DEPTH);
            if (s_vec_we) pushes++;
            s_vec_wbr = AW'(10 + c); s_vec_data = rand_vec(); s_vec_mask = (c == 1) ? 4'h0 : 4'($urandom);
            step();
        end
        idle_inputs();
        check("fill_pushes", pushes, DEPTH);
    endtask

    initial begin
        last_reg = '0; last_vec = '0; merr = 0;
        do_reset();

        // Plain direct scalar write.
        s_reg_we = 1; s_reg_wbr = 3; s_reg_data = 36'h1;
        step();
        idle_inputs();
        check("t1_port", {reg_we, reg_wbr, reg_data}, {1'b1, 5'd3, 36'h1});
        check("t1_pending", reg_pending, 0);
        step();

        // Link write uses the PC.
        s_reg_we = 1; s_pc_sel = 1; s_pc = 36'h104; s_reg_wbr = 31; s_reg_data = 36'hDEAD;
        step();
        idle_inputs();
        check("t2_port", {reg_we, reg_wbr, reg_data}, {1'b1, 5'd31, 36'h104});
        step();

        // Scalar loses to vector pipe, retires the next cycle.
        s_reg_we = 1; s_reg_wbr = 2; s_reg_data = 36'hA;
        v_reg_we = 1; v_reg_wbr = 5; v_reg_data = 36'hB;
        step();
        idle_inputs();
        check("t3_first", {reg_wbr, reg_data, reg_pending}, {5'd5, 36'hB, 32'h4});
        step();
        check("t3_second", {reg_wbr, reg_data, reg_pending}, {5'd2, 36'hA, 32'h0});
        step();

        // Vector FIFO fills to stall, then drains in order.
        fill_vec(6);
        check("t4_stall_set", stall, 1);
        step();
        check("t4_stall_clear", {stall, err}, 0);
        repeat (5) step();

        // Scalar write while stalled is dropped and sets err.
        fill_vec(5);
        s_reg_we = 1; s_reg_wbr = 7; s_reg_data = 36'h77;
        v_vec_we = 1; v_vec_wbr = 1; v_vec_data = rand_vec();
        step();
        idle_inputs();
        check("t5_err", err, 1);
        repeat (6) step();
        check("t5_err_sticky", err, 1);

        // Reset with entries queued discards them.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            v_vec_we = 1; v_vec_wbr = AW'(c); v_vec_data = rand_vec();
            s_vec_we = 1; s_vec_wbr = AW'(20 + c); s_vec_data = rand_vec(); s_vec_mask = 4'hF;
            step();
        end
        check("t6_queued", vec_pending, 32'h0070_0000);
        do_reset();
        repeat (5) step();

        // Randomized traffic with occasional mid-run resets.
        for (int c = 0; c < 600; c++) begin
            bit st = model_stall();
            s_reg_we   = st ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) < 6);
            s_reg_wbr  = AW'($urandom);
            s_reg_data = {4'($urandom), 32'($urandom)};
            s_pc_sel   = $urandom_range(0, 3) == 0;
            s_pc       = {4'($urandom), 32'($urandom)};
            v_reg_we   = $urandom_range(0, 9) < 4;
            v_reg_wbr  = AW'($urandom);
            v_reg_data = {4'($urandom), 32'($urandom)};
            s_vec_we   = st ? ($urandom_range(0, 19) == 0) : ($urandom_range(0, 9) < 6);
            s_vec_wbr  = AW'($urandom);
            s_vec_data = rand_vec();
            s_vec_mask = 4'($urandom);
            v_vec_we   = $urandom_range(0, 9) < 5;
            v_vec_wbr  = AW'($urandom);
            v_vec_data = rand_vec();
            v_vec_mask = 4'($urandom);
            step();
            if (c % 150 == 149) do_reset();
        end

        idle_inputs();
        repeat (DEPTH + 3) step();
        check("drain_reg", exp_reg.size() + mreg.size(), 0);
        check("drain_vec", exp_vec.size() + mvec.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
